// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM of the multi-cycle datapath.
// Drives every datapath select/enable per step, stalls on mem_ready, counts retirements.
`default_nettype none

module multicycle_control #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             pcwritecond,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             irwrite,
   output logic             memtoreg,
   output logic             regdst,
   output logic             regwrite,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       pcsource,
   output logic [2:0]       aluop,
   output logic             branch_ne,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADDR  = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IMM_EX   = 4'd10,
      S_IMM_WB   = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_SLTI = 6'b001010;

   state_t           state_q, state_d;
   logic [5:0]       op_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         op_q    <= 6'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= opcode;
         end
         if (instr_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'b00;
      pcsource    = 2'b00;
      aluop       = 3'b000;
      branch_ne   = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;

      case (state_q)
         S_FETCH: begin
            memread = 1'b1;
            alusrcb = 2'b01;
            aluop   = 3'b001;
            pcwrite = mem_ready;
            irwrite = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            aluop   = 3'b001;
            // The only path from the live opcode: dispatch and the illegal flag.
            case (opcode)
               OP_R:                                state_d = S_RTYPE_EX;
               OP_LW, OP_SW:                        state_d = S_MEMADDR;
               OP_BEQ, OP_BNE:                      state_d = S_BRANCH;
               OP_J:                                state_d = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = S_IMM_EX;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADDR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = 3'b001;
            state_d = (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            memread = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite   = 1'b1;
            memtoreg   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            memwrite   = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = S_FETCH;
         end
         S_RTYPE_EX: begin
            alusrca = 1'b1;
            state_d = S_RTYPE_WB;
         end
         S_RTYPE_WB: begin
            regdst     = 1'b1;
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alusrca     = 1'b1;
            aluop       = 3'b010;
            pcwritecond = 1'b1;
            pcsource    = 2'b01;
            branch_ne   = (op_q == OP_BNE);
            instr_done  = 1'b1;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            pcwrite    = 1'b1;
            pcsource   = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_IMM_EX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            case (op_q)
               OP_ANDI: aluop = 3'b011;
               OP_ORI:  aluop = 3'b100;
               OP_SLTI: aluop = 3'b101;
               default: aluop = 3'b001;
            endcase
            state_d = S_IMM_WB;
         end
         S_IMM_WB: begin
            regwrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign state       = state_q;
   assign instr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random + directed stimulus against an instruction-level model.
`default_nettype none

module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_SLTI = 6'b001010;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b1;

   always #5 clk = ~clk;

   // DUT 1 (default counter width)
   logic        pw1, pwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1, bne1, done1, ill1;
   logic [1:0]  bsel1, psrc1;
   logic [2:0]  aop1;
   logic [3:0]  st1;
   logic [15:0] cnt1;

   // DUT 2 (2-bit counter to exercise wrap)
   logic        pw2, pwc2, iord2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, asa2, bne2, done2, ill2;
   logic [1:0]  bsel2, psrc2;
   logic [2:0]  aop2;
   logic [3:0]  st2;
   logic [1:0]  cnt2;

   multicycle_control #(.CNT_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .pcwrite(pw1), .pcwritecond(pwc1), .iord(iord1), .memread(mrd1), .memwrite(mwr1),
      .irwrite(irw1), .memtoreg(m2r1), .regdst(rdst1), .regwrite(rw1), .alusrca(asa1),
      .alusrcb(bsel1), .pcsource(psrc1), .aluop(aop1), .branch_ne(bne1), .state(st1),
      .instr_done(done1), .illegal(ill1), .instr_count(cnt1)
   );

   multicycle_control #(.CNT_W(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
      .pcwrite(pw2), .pcwritecond(pwc2), .iord(iord2), .memread(mrd2), .memwrite(mwr2),
      .irwrite(irw2), .memtoreg(m2r2), .regdst(rdst2), .regwrite(rw2), .alusrca(asa2),
      .alusrcb(bsel2), .pcsource(psrc2), .aluop(aop2), .branch_ne(bne2), .state(st2),
      .instr_done(done2), .illegal(ill2), .instr_count(cnt2)
   );

   wire [23:0] vec1 = {pw1, pwc1, iord1, mrd1, mwr1, irw1, m2r1, rdst1, rw1, asa1,
                       bsel1, psrc1, aop1, bne1, st1, done1, ill1};
   wire [23:0] vec2 = {pw2, pwc2, iord2, mrd2, mwr2, irw2, m2r2, rdst2, rw2, asa2,
                       bsel2, psrc2, aop2, bne2, st2, done2, ill2};

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, expv);
      end
   endtask

   function automatic logic is_legal(input logic [5:0] op);
      return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
   endfunction

   // Model: an instruction is a list of post-decode steps; it retires on its last step.
   int         cur = 0;
   logic [5:0] mop = 6'd0;
   int         plan[$];
   int         mcount = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur = 0; mop = 6'd0; plan.delete(); mcount = 0;
      end else if (cur == 0) begin
         if (mem_ready) cur = 1;
      end else if (cur == 1) begin
         mop = opcode;
         case (opcode)
            OP_R:                              plan = '{6, 7};
            OP_LW:                             plan = '{2, 3, 4};
            OP_SW:                             plan = '{2, 5};
            OP_BEQ, OP_BNE:                    plan = '{8};
            OP_J:                              plan = '{9};
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: plan = '{10, 11};
            default:                           plan.delete();
         endcase
         cur = (plan.size() == 0) ? 0 : plan.pop_front();
      end else if ((cur == 3 || cur == 5) && !mem_ready) begin
         cur = cur;
      end else if (plan.size() == 0) begin
         mcount++;
         cur = 0;
      end else begin
         cur = plan.pop_front();
      end
   end

   function automatic logic [23:0] expect_ctl(input int s, input logic [5:0] op,
                                              input logic mr, input logic [5:0] live,
                                              input logic last);
      logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, bn, dn, il;
      logic [1:0] bs, ps;
      logic [2:0] ao;
      {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, bn, dn, il} = '0;
      bs = 2'd0; ps = 2'd0; ao = 3'd0;
      case (s)
         0:  begin mrd = 1; bs = 2'd1; ao = 3'd1; pw = mr; irw = mr; end
         1:  begin bs = 2'd3; ao = 3'd1; il = !is_legal(live); end
         2:  begin asa = 1; bs = 2'd2; ao = 3'd1; end
         3:  begin mrd = 1; io = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mwr = 1; io = 1; end
         6:  begin asa = 1; end
         7:  begin rd = 1; rw = 1; end
         8:  begin asa = 1; ao = 3'd2; pwc = 1; ps = 2'd1; bn = (op == OP_BNE); end
         9:  begin pw = 1; ps = 2'd2; end
         10: begin
                asa = 1; bs = 2'd2;
                ao = (op == OP_ANDI) ? 3'd3 : (op == OP_ORI) ? 3'd4 : (op == OP_SLTI) ? 3'd5 : 3'd1;
             end
         11: begin rw = 1; end
         default: ;
      endcase
      dn = (s >= 2) && last && !(s == 5 && !mr);
      return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, asa, bs, ps, ao, bn, 4'(s), dn, il};
   endfunction

   // Single compare process, mid-cycle where inputs and outputs are settled.
   always @(negedge clk) begin
      logic [23:0] e;
      e = expect_ctl(cur, mop, mem_ready, opcode, plan.size() == 0);
      chk("ctl", 32'(vec1), 32'(e));
      chk("ctl_w2", 32'(vec2), 32'(e));
      chk("count", 32'(cnt1), 32'(mcount % 65536));
      chk("count_w2", 32'(cnt2), 32'(mcount % 4));
   end

   int         st_log[$];
   logic [2:0] aop_log[$];
   logic       bne_log[$];
   logic       ill_log[$];
   int         exp_q[$];

   task automatic step(input logic [5:0] op, input logic mr);
      opcode = op;
      mem_ready = mr;
      @(negedge clk);
      st_log.push_back(int'(st1));
      aop_log.push_back(aop1);
      bne_log.push_back(bne1);
      ill_log.push_back(ill1);
      @(posedge clk);
      #1;
   endtask

   task automatic clr_logs();
      st_log.delete(); aop_log.delete(); bne_log.delete(); ill_log.delete();
   endtask

   task automatic chk_seq(input string nm);
      chk({nm, "_len"}, 32'(st_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < st_log.size(); i++)
         chk(nm, 32'(st_log[i]), 32'(exp_q[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] legal_ops[10];
      logic [5:0] imm_ops[4];
      logic [2:0] imm_aop[4];
      logic [15:0] cnt_before;
      int n;
      legal_ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
      imm_ops   = '{OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
      imm_aop   = '{3'd1, 3'd3, 3'd4, 3'd5};

      // Reset state: FETCH values with mem_ready=1
      #3;
      chk("rst_state", 32'(st1), 32'd0);
      chk("rst_memread_irwrite", 32'({mrd1, irw1, pw1, bsel1, aop1}), 32'b1_1_1_01_001);
      chk("rst_count", 32'(cnt1), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;

      // R-type
      clr_logs();
      repeat (4) step(OP_R, 1'b1);
      exp_q = '{0, 1, 6, 7};
      chk_seq("rtype_seq");
      chk("rtype_aop0", 32'(aop_log[0]), 32'd1);
      chk("rtype_aop1", 32'(aop_log[1]), 32'd1);
      chk("rtype_aop2", 32'(aop_log[2]), 32'd0);
      chk("rtype_count", 32'(cnt1), 32'd1);

      // lw with two stall cycles in MEMREAD; opcode scrambled after decode
      clr_logs();
      step(OP_LW, 1'b1); step(OP_LW, 1'b1);
      step(6'($urandom), 1'b1); step(6'($urandom), 1'b0); step(6'($urandom), 1'b0);
      step(6'($urandom), 1'b1); step(6'($urandom), 1'b1);
      exp_q = '{0, 1, 2, 3, 3, 3, 4};
      chk_seq("lw_seq");
      chk("lw_count", 32'(cnt1), 32'd2);

      // Immediates back-to-back
      for (int k = 0; k < 4; k++) begin
         clr_logs();
         repeat (4) step(imm_ops[k], 1'b1);
         chk("imm_aop", 32'(aop_log[2]), 32'(imm_aop[k]));
         chk("imm_state", 32'(st_log[2]), 32'd10);
      end
      chk("imm_count", 32'(cnt1), 32'd6);
      chk("imm_count_w2", 32'(cnt2), 32'd2);

      // bne then j; the 2-bit counter wraps 3 -> 0 on the j
      clr_logs();
      repeat (3) step(OP_BNE, 1'b1);
      exp_q = '{0, 1, 8};
      chk_seq("bne_seq");
      chk("bne_flag", 32'(bne_log[2]), 32'd1);
      chk("bne_count_w2", 32'(cnt2), 32'd3);
      clr_logs();
      repeat (3) step(OP_J, 1'b1);
      exp_q = '{0, 1, 9};
      chk_seq("j_seq");
      chk("j_count", 32'(cnt1), 32'd8);
      chk("wrap_count_w2", 32'(cnt2), 32'd0);

      // Illegal opcode
      clr_logs();
      repeat (2) step(6'h3f, 1'b1);
      chk("ill_flag", 32'(ill_log[1]), 32'd1);
      chk("ill_next_state", 32'(st1), 32'd0);
      chk("ill_count", 32'(cnt1), 32'd8);

      // Random phase
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 9)];
         step(op, $urandom_range(0, 3) != 0);
      end

      // Drain to FETCH, then reset in the middle of a stalled sw
      n = 0;
      while (cur != 0 && n < 20) begin
         step(OP_R, 1'b1);
         n++;
      end
      chk("drain_fetch", 32'(cur), 32'd0);
      step(OP_SW, 1'b1); step(OP_SW, 1'b1); step(6'($urandom), 1'b1);
      mem_ready = 1'b0;
      #3;
      chk("sw_in_memwrite", 32'(st1), 32'd5);
      cnt_before = cnt1;
      chk("sw_count_nonzero", 32'(cnt_before != 16'd0), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_state", 32'(st1), 32'd0);
      chk("midrst_done", 32'({done1, done2}), 32'd0);
      chk("midrst_count", 32'(cnt1), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      mem_ready = 1'b1;
      repeat (4) step(OP_R, 1'b1);
      chk("post_rst_count", 32'(cnt1), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
